prog_clk_div: RTL and testbench
===============================

# prog_clk_div

Runtime-programmable synchronous frequency divider, the parametrised successor to the fixed divide-by-8 toggle-flop chain. It divides `clk` by any integer N in 1..2^WIDTH-1 and produces a registered, glitch-free divided output `fout` plus a one-cycle `tick` strobe per period. The divisor can be changed on the fly and takes effect only at a period boundary. The block sits in the clock-enable / timebase layer, feeding baud, PWM and sampling logic.

## Interface
- `WIDTH`, 8: counter and divisor width; legal N is 1..2^WIDTH-1.
- `DEFAULT_DIV`, 8: divisor loaded at reset; must be in 2..2^WIDTH-1.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `en` in 1: count enable; when low, all state freezes.
- `sync_clr` in 1: synchronous restart of the period; has priority over `en`.
- `div_in` in WIDTH: new divisor value.
- `div_load` in 1: single-cycle request to load `div_in`.
- `fout` out 1: divided output, registered.
- `tick` out 1: strobe for the last cycle of each period.
- `cnt` out WIDTH: current phase count, 0..N-1.
- `div_cur` out WIDTH: divisor in effect.
- `div_busy` out 1: a loaded divisor is pending and not yet applied.
- `load_err` out 1: one-cycle pulse; the previous cycle's `div_load` carried 0 and was rejected.

## Operation
- **Reset values:**
  - `cnt`=0, `div_cur`=DEFAULT_DIV, pending register=DEFAULT_DIV.
  - `div_busy`=0, `load_err`=0, `fout`=0, `tick`=0.
- **Counting:** N = `div_cur`. On a cycle with `en`=1 and `sync_clr`=0:
  - If `cnt`==N-1 (the wrap cycle): `cnt`<=0.
  - Otherwise: `cnt`<=`cnt`+1.
- **tick:** `tick` = `reset_n` & `en` & !`sync_clr` & (`cnt`==N-1). It is combinational from registers. For N=1, `tick` is high on every enabled cycle.
- **fout invariant:** `fout` == (`cnt` >= `div_cur`>>1) holds on every cycle after reset.
  - Implement it by registering the value computed from next-state `cnt` and `div_cur`.
  - Resulting shape: high for ceil(N/2) cycles, low for floor(N/2), low phase first.
  - N=8 gives 4 low / 4 high. N=5 gives 2 low / 3 high. N=1 gives `fout` constant 1.
- **Divisor load:**
  - `div_load`=1 with `div_in`!=0: pending<=`div_in`, `div_busy`<=1.
  - `div_load`=1 with `div_in`==0: ignored; `load_err`=1 on the next cycle only.
  - A load while `div_busy`=1 overwrites pending. The last load wins.
- **Apply:** On a wrap cycle with `div_busy`=1, `div_cur`<=pending and `div_busy`<=0.
- **Load coinciding with a wrap:**
  - The apply uses the pre-cycle pending and busy state.
  - The new value lands in pending with `div_busy`=1 and applies at the following wrap.
  - If `div_busy` was 0 before that cycle, nothing is applied on it.
- **en=0:**
  - `cnt`, `fout`, `div_cur` hold; `tick`=0; no apply.
  - Loads are still accepted into pending.
- **sync_clr=1:**
  - `cnt`<=0 and `tick`=0.
  - If `div_busy`, pending applies immediately and `div_busy`<=0.
  - `fout` follows the invariant with `cnt`=0, so it is 0 unless the new N=1.
  - A `div_load` in the same cycle behaves as a load coinciding with a wrap.
- **Async reset mid-period:** all registers return to reset values immediately; any pending load is discarded.

## Timing
- Period = N enabled cycles. `tick` occurs once per period, in the cycle where `cnt`==N-1.
- Load-to-effect latency: the new N governs the first period starting after the next wrap (or `sync_clr`). `cnt` never exceeds N-1 of the divisor in effect.
- Minimum latency is 1 cycle: a load on cycle k with the wrap on k+1 means `div_cur` is updated at k+2.
- `fout` changes only on `clk` rising edges and is glitch-free across divisor changes.
- Divisor changes never produce a truncated period.

## Test plan
- **Default divide:** reset, then `en`=1 for 32 cycles.
  - `cnt` cycles 0..7.
  - `fout`=0 while `cnt` is 0..3 and 1 while `cnt` is 4..7.
  - `tick` at `cnt`=7, four times.
  - `fout` is low at reset.
- **Odd divisor and N=1:**
  - Load 5: after the next wrap, the period is 5 with `fout` low 2 / high 3.
  - Load 1: `fout` stays 1 and `tick` is high on every enabled cycle.
- **Boundary-safe load:**
  - Load 3 at `cnt`=2 of N=8: `div_busy`=1; counting continues to 7; `div_cur`=3 from `cnt`=0.
  - Load 6 issued exactly on the wrap cycle: applies one period later.
- **Overwrite and reject:**
  - Load 4 then 10 before a wrap: 10 applies and 4 is never seen.
  - Load 0: `load_err` pulses for 1 cycle; `div_cur` and `div_busy` are unchanged.
- **en / sync_clr:**
  - `en` low for 5 cycles mid-period: `cnt` and `fout` frozen, `tick`=0.
  - `sync_clr` at `cnt`=5 with a pending 12: `cnt`=0, `div_cur`=12, `fout`=0.
- **Async reset mid-period:** assert `reset_n` low at `cnt`=6 with a load pending.
  - All outputs return to reset values immediately.
  - After release, `div_cur`=8.

Source files
------------

// File: rtl/prog_clk_div.sv
// Runtime-programmable synchronous clock divider: divides clk by N (1..2^WIDTH-1),
// with a registered glitch-free fout, a per-period tick, and boundary-safe divisor loads.
module prog_clk_div #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             fout,
    output logic             tick,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] div_cur,
    output logic             div_busy,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div_cur;
    logic [WIDTH-1:0] r_pend;
    logic             r_busy;
    logic             r_load_err;
    logic             r_fout;

    logic             w_last;
    logic             w_wrap;
    logic             w_apply;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_div_nxt;
    logic             w_fout_nxt;

    assign w_last    = (r_cnt == (r_div_cur - WIDTH'(1)));
    assign w_wrap    = en & ~sync_clr & w_last;
    // A pending divisor is applied on a wrap or a restart, using pre-cycle busy/pending.
    assign w_apply   = r_busy & (sync_clr | w_wrap);
    assign w_load_ok = div_load & (div_in != '0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (sync_clr) begin
            w_cnt_nxt = '0;
        end else if (en) begin
            w_cnt_nxt = w_last ? '0 : r_cnt + WIDTH'(1);
        end
    end

    assign w_div_nxt  = w_apply ? r_pend : r_div_cur;
    // fout is registered from next-state values so fout == (cnt >= div_cur/2) every cycle.
    assign w_fout_nxt = (w_cnt_nxt >= (w_div_nxt >> 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_div_cur  <= DEF_DIV;
            r_pend     <= DEF_DIV;
            r_busy     <= 1'b0;
            r_load_err <= 1'b0;
            r_fout     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_div_cur  <= w_div_nxt;
            r_fout     <= w_fout_nxt;
            r_load_err <= div_load & (div_in == '0);
            if (w_load_ok) begin
                r_pend <= div_in;
                r_busy <= 1'b1;
            end else if (w_apply) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign tick     = reset_n & w_wrap;
    assign fout     = r_fout;
    assign cnt      = r_cnt;
    assign div_cur  = r_div_cur;
    assign div_busy = r_busy;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div: reset, default divide, a hand-computed vector
// table covering loads, wraps, en/sync_clr, N=1, then an async reset sequence.
module tb_prog_clk_div;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       sync_clr;
    logic [7:0] div_in;
    logic       div_load;
    logic       fout;
    logic       tick;
    logic [7:0] cnt;
    logic [7:0] div_cur;
    logic       div_busy;
    logic       load_err;

    int n_tests = 0;
    int n_fail  = 0;

    prog_clk_div #(.WIDTH(8), .DEFAULT_DIV(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .sync_clr (sync_clr),
        .div_in   (div_in),
        .div_load (div_load),
        .fout     (fout),
        .tick     (tick),
        .cnt      (cnt),
        .div_cur  (div_cur),
        .div_busy (div_busy),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs apply during one cycle; expected values are outputs seen in that cycle.
    typedef struct {
        logic       en;
        logic       clr;
        logic       ld;
        logic [7:0] din;
        logic [7:0] cnt;
        logic       tick;
        logic       fout;
        logic [7:0] div;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic e, input logic c, input logic l, input logic [7:0] d,
                              input logic [7:0] xc, input logic xt, input logic xf,
                              input logic [7:0] xd, input logic xb, input logic xe);
        vec_t r;
        r.en = e; r.clr = c; r.ld = l; r.din = d;
        r.cnt = xc; r.tick = xt; r.fout = xf; r.div = xd; r.busy = xb; r.err = xe;
        vecs.push_back(r);
    endfunction

    // Plain enabled counting with a fixed divisor: cnt wraps mod nd, fout high in upper half.
    function automatic void run(input int n, input int c0, input int nd, input logic b);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (c0 + k) % nd;
            v(1, 0, 0, 8'd0, 8'(c), (c == nd - 1), (c >= nd / 2), 8'(nd), b, 0);
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int xc, input int xt, input int xf,
                           input int xd, input int xb, input int xe);
        chk({tag, ".cnt"},      int'(cnt),      xc);
        chk({tag, ".tick"},     int'(tick),     xt);
        chk({tag, ".fout"},     int'(fout),     xf);
        chk({tag, ".div_cur"},  int'(div_cur),  xd);
        chk({tag, ".div_busy"}, int'(div_busy), xb);
        chk({tag, ".load_err"}, int'(load_err), xe);
    endtask

    initial begin
        int ticks;
        reset_n = 1'b0; en = 1'b0; sync_clr = 1'b0; div_in = 8'd0; div_load = 1'b0;

        // Boundary load / wrap-coincident load / odd N / overwrite / reject
        run(2, 0, 8, 0);
        v(1, 0, 1, 8'd3,  8'd2, 0, 0, 8'd8, 0, 0);
        run(5, 3, 8, 1);
        run(3, 0, 3, 0);
        run(2, 0, 3, 0);
        v(1, 0, 1, 8'd6,  8'd2, 1, 1, 8'd3, 0, 0);
        run(3, 0, 3, 1);
        run(6, 0, 6, 0);
        v(1, 0, 1, 8'd5,  8'd0, 0, 0, 8'd6, 0, 0);
        run(5, 1, 6, 1);
        run(5, 0, 5, 0);
        v(1, 0, 1, 8'd4,  8'd0, 0, 0, 8'd5, 0, 0);
        v(1, 0, 1, 8'd10, 8'd1, 0, 0, 8'd5, 1, 0);
        run(3, 2, 5, 1);
        v(1, 0, 1, 8'd0,  8'd0, 0, 0, 8'd10, 0, 0);
        v(1, 0, 0, 8'd0,  8'd1, 0, 0, 8'd10, 0, 1);
        run(9, 2, 10, 0);
        run(5, 1, 10, 0);
        // en low mid-period, with a load accepted while frozen
        v(0, 0, 1, 8'd10, 8'd6, 0, 1, 8'd10, 0, 0);
        for (int k = 0; k < 4; k++) v(0, 0, 0, 8'd0, 8'd6, 0, 1, 8'd10, 1, 0);
        run(3, 6, 10, 1);
        v(0, 0, 0, 8'd0,  8'd9, 0, 1, 8'd10, 1, 0);
        v(1, 0, 0, 8'd0,  8'd9, 1, 1, 8'd10, 1, 0);
        // sync_clr at cnt=5 with pending 12
        v(1, 0, 0, 8'd0,  8'd0, 0, 0, 8'd10, 0, 0);
        v(1, 0, 1, 8'd12, 8'd1, 0, 0, 8'd10, 0, 0);
        run(3, 2, 10, 1);
        v(1, 1, 0, 8'd0,  8'd5, 0, 1, 8'd10, 1, 0);
        v(1, 0, 0, 8'd0,  8'd0, 0, 0, 8'd12, 0, 0);
        // N=1 via sync_clr that overrides en=0, then a load coinciding with sync_clr
        v(1, 0, 1, 8'd1,  8'd1, 0, 0, 8'd12, 0, 0);
        v(0, 1, 0, 8'd0,  8'd2, 0, 0, 8'd12, 1, 0);
        v(1, 0, 0, 8'd0,  8'd0, 1, 1, 8'd1, 0, 0);
        v(1, 0, 0, 8'd0,  8'd0, 1, 1, 8'd1, 0, 0);
        v(0, 0, 0, 8'd0,  8'd0, 0, 1, 8'd1, 0, 0);
        v(1, 1, 0, 8'd0,  8'd0, 0, 1, 8'd1, 0, 0);
        v(1, 1, 1, 8'd8,  8'd0, 0, 1, 8'd1, 0, 0);
        v(1, 0, 0, 8'd0,  8'd0, 1, 1, 8'd1, 1, 0);
        // Back to N=8 with 9 pending when reset hits at cnt=6
        v(1, 0, 0, 8'd0,  8'd0, 0, 0, 8'd8, 0, 0);
        v(1, 0, 1, 8'd9,  8'd1, 0, 0, 8'd8, 0, 0);
        run(4, 2, 8, 1);

        // Reset
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_all("reset", 0, 0, 0, 8, 0, 0);

        // Default divide by 8 for 32 cycles
        ticks = 0;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            en = 1'b1;
            #1;
            chk("dflt.cnt",  int'(cnt),  i % 8);
            chk("dflt.fout", int'(fout), int'((i % 8) >= 4));
            chk("dflt.tick", int'(tick), int'((i % 8) == 7));
            if (tick) ticks++;
        end
        chk("dflt.tick_count", ticks, 4);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            en = vecs[i].en; sync_clr = vecs[i].clr; div_load = vecs[i].ld; div_in = vecs[i].din;
            #1;
            chk_all($sformatf("vec%0d", i), int'(vecs[i].cnt), int'(vecs[i].tick),
                    int'(vecs[i].fout), int'(vecs[i].div), int'(vecs[i].busy), int'(vecs[i].err));
        end

        // Async reset mid-period with 9 pending
        @(negedge clk);
        en = 1'b1; sync_clr = 1'b0; div_load = 1'b0; div_in = 8'd0;
        #1;
        chk("pre_rst.cnt",  int'(cnt),      6);
        chk("pre_rst.busy", int'(div_busy), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 8, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("post_rst.cnt",  int'(cnt),      i % 8);
            chk("post_rst.tick", int'(tick),     int'(i == 7));
            chk("post_rst.div",  int'(div_cur),  8);
            chk("post_rst.busy", int'(div_busy), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
